// File: rtl/mul_arbiter.sv
// -----------------------------------------------------------------------------
// mul_arbiter
//
// Shares one combinational 16x16 multiplier between two requesters:
//   port 0 : execute stage
//   port 1 : auxiliary / debug port
//
// A round-robin arbiter picks one request while idle and registers its
// operands onto the multiplier inputs. The multiplier tree is a MUL_CYCLES
// multicycle path, so the block waits that many cycles before sampling the
// product. The product is then returned on a valid/ready response channel,
// tagged with the requester id and the requester's tag.
//
// Parameters:
//   MUL_CYCLES  cycles the operands are held before the product is sampled
//               (legal range 1..15)
//   TAG_W       width of the requester tag
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   req{0,1}_valid/_ready         request handshake (ready is combinational)
//   req{0,1}_a/_b                 operands, only [15:0] reach the product
//   req{0,1}_tag                  tag carried through to the response
//   resp_valid/resp_ready         response handshake
//   resp_id, resp_tag             issuing requester and its tag
//   resp_result                   captured 32-bit product
//   resp_trunc                    operand bits [31:16] were nonzero
//   mul_a, mul_b, mul_is_mul      drive the shared multiplier
//   mul_result                    product from the shared multiplier
//   busy                          an operation is in flight
//
// Optional build macro:
//   MUL_ARB_ZERO_BYPASS_EN  when defined, an operation whose low operand half
//                           is zero in A or B skips the multiplier wait and
//                           answers 0 one cycle after acceptance.
// -----------------------------------------------------------------------------
module mul_arbiter #(
   parameter int MUL_CYCLES = 2,
   parameter int TAG_W      = 4
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [TAG_W-1:0] req0_tag,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [TAG_W-1:0] req1_tag,

   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [TAG_W-1:0] resp_tag,
   output logic [31:0]      resp_result,
   output logic             resp_trunc,

   output logic [31:0]      mul_a,
   output logic [31:0]      mul_b,
   output logic             mul_is_mul,
   input  logic [31:0]      mul_result,

   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter reload: the capture happens on the edge where the counter is
   // already zero, so loading MUL_CYCLES-1 gives exactly MUL_CYCLES edges
   // in WAIT.
   localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Per-port views so the grant can simply index by requester id
   // ---------------------------------------------------------------------
   logic [31:0]      port_a     [2];
   logic [31:0]      port_b     [2];
   logic [TAG_W-1:0] port_tag   [2];
   logic [1:0]       port_trunc;

   assign port_a[0]   = req0_a;
   assign port_a[1]   = req1_a;
   assign port_b[0]   = req0_b;
   assign port_b[1]   = req1_b;
   assign port_tag[0] = req0_tag;
   assign port_tag[1] = req1_tag;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         // High operand halves never reach the 16x16 tree; flag them so the
         // requester can tell the product was computed on truncated inputs.
         assign port_trunc[gi] = (|port_a[gi][31:16]) | (|port_b[gi][31:16]);
      end
   endgenerate

`ifdef MUL_ARB_ZERO_BYPASS_EN
   logic [1:0] port_zero;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_zero
         assign port_zero[gi] = (port_a[gi][15:0] == 16'h0000) |
                                (port_b[gi][15:0] == 16'h0000);
      end
   endgenerate
`endif

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t           state_reg,  state_next;
   logic [3:0]       cnt_reg,    cnt_next;
   logic             ptr_reg,    ptr_next;
   logic [31:0]      a_reg,      a_next;
   logic [31:0]      b_reg,      b_next;
   logic [TAG_W-1:0] tag_reg,    tag_next;
   logic             id_reg,     id_next;
   logic             trunc_reg,  trunc_next;
   logic [31:0]      result_reg, result_next;

   // ---------------------------------------------------------------------
   // Round-robin grant. A lone valid port always wins; on contention the
   // pointer decides. The pointer only moves when a grant is taken.
   // ---------------------------------------------------------------------
   logic grant_any;
   logic grant_id;
   logic idle;

   always_comb begin
      grant_any = req0_valid | req1_valid;
      if (req0_valid & req1_valid) begin
         grant_id = ptr_reg;
      end else begin
         grant_id = req1_valid;
      end
   end

   assign idle = (state_reg == ST_IDLE);

   // Ready is qualified with rst_n so every output reads 0 while reset is
   // held, even if a requester is already presenting a request.
   assign req0_ready = rst_n & idle & req0_valid & ~grant_id;
   assign req1_ready = rst_n & idle & req1_valid &  grant_id;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= 4'd0;
         ptr_reg    <= 1'b0;
         a_reg      <= 32'd0;
         b_reg      <= 32'd0;
         tag_reg    <= '0;
         id_reg     <= 1'b0;
         trunc_reg  <= 1'b0;
         result_reg <= 32'd0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         ptr_reg    <= ptr_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         tag_reg    <= tag_next;
         id_reg     <= id_next;
         trunc_reg  <= trunc_next;
         result_reg <= result_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      ptr_next    = ptr_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      tag_next    = tag_reg;
      id_next     = id_reg;
      trunc_next  = trunc_reg;
      result_next = result_reg;

      case (state_reg)
         ST_IDLE: begin
            if (grant_any) begin
               ptr_next   = ~grant_id;
               a_next     = port_a[grant_id];
               b_next     = port_b[grant_id];
               tag_next   = port_tag[grant_id];
               id_next    = grant_id;
               trunc_next = port_trunc[grant_id];
               cnt_next   = CNT_LOAD;
               state_next = ST_WAIT;
`ifdef MUL_ARB_ZERO_BYPASS_EN
               // A zero factor makes the product known without waiting on
               // the multiplier tree.
               if (port_zero[grant_id]) begin
                  cnt_next    = 4'd0;
                  result_next = 32'd0;
                  state_next  = ST_DONE;
               end
`endif
            end
         end

         ST_WAIT: begin
            if (cnt_reg == 4'd0) begin
               result_next = mul_result;
               state_next  = ST_DONE;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end

         ST_DONE: begin
            if (resp_ready) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign mul_a       = a_reg;
   assign mul_b       = b_reg;
   assign mul_is_mul  = (state_reg == ST_WAIT);

   assign resp_valid  = (state_reg == ST_DONE);
   assign resp_id     = id_reg;
   assign resp_tag    = tag_reg;
   assign resp_result = result_reg;
   assign resp_trunc  = trunc_reg;

   assign busy        = ~idle;

endmodule
